// File: rtl/lut_search_ctrl.sv
// Match-gated lookup controller: a small {key, data} table with a sequential
// one-entry-per-cycle search and a valid/ready response port.
module lut_search_ctrl #(
  parameter int D     = 8,
  parameter int KW    = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [KW-1:0] wr_key,
  input  logic [D-1:0]  wr_data,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [KW-1:0] req_key,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic [AW-1:0] rsp_idx,
  output logic [D-2:0]  rsp_data
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam int unsigned   DEPTH_U  = DEPTH;

  state_e          state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [KW-1:0]   key_q  [DEPTH];
  logic [KW-1:0]   key_d  [DEPTH];
  // Bit 0 of an entry is never returned, so only data[D-1:1] is stored.
  logic [D-2:0]    data_q [DEPTH];
  logic [D-2:0]    data_d [DEPTH];
  logic [AW-1:0]   idx_q, idx_d;
  logic [KW-1:0]   skey_q, skey_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_hit_q, rsp_hit_d;
  logic [AW-1:0]   rsp_idx_q, rsp_idx_d;
  logic [D-2:0]    rsp_data_q, rsp_data_d;
  logic            hit;
  logic            unused_wr_lsb;

  assign unused_wr_lsb = wr_data[0];

  always_comb begin
    valid_d     = valid_q;
    key_d       = key_q;
    data_d      = data_q;
    state_d     = state_q;
    idx_d       = idx_q;
    skey_d      = skey_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_data_d  = rsp_data_q;

    if (wr_en && (32'(wr_addr) < DEPTH_U)) begin
      key_d[wr_addr]   = wr_key;
      data_d[wr_addr]  = wr_data[D-1:1];
      valid_d[wr_addr] = 1'b1;
    end
    if (clr) begin
      valid_d = '0;
    end

    // Compare uses the registered table, so same-cycle writes are not seen here.
    hit = valid_q[idx_q] & (key_q[idx_q] == skey_q);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          skey_d  = req_key;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_idx_d   = idx_q;
          rsp_data_d  = data_q[idx_q];
          state_d     = RESP;
        end else if (idx_q == LAST_IDX) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = '0;
          rsp_data_d  = '0;
          state_d     = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    key_q  <= key_d;
    data_q <= data_d;
    if (!rst_n) begin
      valid_q     <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      skey_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      skey_q      <= skey_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == IDLE) & rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lut_search_ctrl.sv
// Bench for lut_search_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the table and search timing.
module tb_lut_search_ctrl;

  localparam int D     = 8;
  localparam int KW    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] wr_key;
  logic [D-1:0]  wr_data;
  logic          clr;
  logic          req_valid;
  logic          req_ready;
  logic [KW-1:0] req_key;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [AW-1:0] rsp_idx;
  logic [D-2:0]  rsp_data;

  lut_search_ctrl #(.D(D), .KW(KW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_key    (wr_key),
    .wr_data   (wr_data),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: table contents plus one outstanding search described by the edge
  // it was accepted on; entry p is judged against the table as it stood at edge acc+1+p.
  bit            m_valid [DEPTH];
  logic [KW-1:0] m_key   [DEPTH];
  logic [D-1:0]  m_data  [DEPTH];
  bit            m_busy, m_found, m_hit;
  int            m_acc_edge, m_idx;
  logic [KW-1:0] m_skey;
  logic [D-2:0]  m_rdata;
  int            edge_no = 0;

  task automatic step();
    bit was_visible, idle_pre;
    int pos;
    logic [D-1:0] ent;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_busy  = 1'b0;
      m_found = 1'b0;
    end else begin
      was_visible = m_busy && m_found;
      idle_pre    = !m_busy;
      if (m_busy && !m_found) begin
        pos = edge_no - m_acc_edge - 1;
        if (m_valid[pos] && m_key[pos] == m_skey) begin
          ent     = m_data[pos];
          m_found = 1'b1;
          m_hit   = 1'b1;
          m_idx   = pos;
          m_rdata = ent[D-1:1];
        end else if (pos == DEPTH - 1) begin
          m_found = 1'b1;
          m_hit   = 1'b0;
          m_idx   = 0;
          m_rdata = '0;
        end
      end
      if (was_visible && rsp_ready) m_busy = 1'b0;
      if (idle_pre && req_valid) begin
        m_busy     = 1'b1;
        m_found    = 1'b0;
        m_acc_edge = edge_no;
        m_skey     = req_key;
      end
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else if (wr_en && int'(wr_addr) < DEPTH) begin
        m_valid[wr_addr] = 1'b1;
        m_key[wr_addr]   = wr_key;
        m_data[wr_addr]  = wr_data;
      end
    end
    @(posedge clk);
    edge_no++;
    #1;
    check("req_ready", req_ready, rst_n && !m_busy);
    check("rsp_valid", rsp_valid, m_busy && m_found);
    if (m_busy && m_found) begin
      check("rsp_hit", rsp_hit, m_hit);
      check("rsp_idx", rsp_idx, m_idx);
      check("rsp_data", rsp_data, m_rdata);
    end
    if (!rst_n) begin
      check("rst_hit", rsp_hit, 0);
      check("rst_idx", rsp_idx, 0);
      check("rst_data", rsp_data, 0);
    end
  endtask

  task automatic write_entry(input int a, input int k, input int dat);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_key  = KW'(k);
    wr_data = D'(dat);
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_tbl();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Issues one search; optional write/clr injected during scan cycle inj_cyc.
  task automatic search(input int key, input int hold, input int inj_cyc, input bit inj_clr,
                        input int ia, input int ik, input int idat,
                        output int lat, output logic got_hit, output logic [AW-1:0] got_idx,
                        output logic [D-2:0] got_data);
    lat      = -1;
    got_hit  = 1'b0;
    got_idx  = '0;
    got_data = '0;
    check("accept_ready", req_ready, 1);
    req_valid = 1'b1;
    req_key   = KW'(key);
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    req_key   = KW'($urandom);
    for (int j = 1; j <= 4 * DEPTH && lat < 0; j++) begin
      if (j == inj_cyc) begin
        if (inj_clr) clr = 1'b1;
        else begin
          wr_en   = 1'b1;
          wr_addr = AW'(ia);
          wr_key  = KW'(ik);
          wr_data = D'(idat);
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      step();
      wr_en = 1'b0;
      clr   = 1'b0;
      if (rsp_valid) begin
        lat      = j + 1;
        got_hit  = rsp_hit;
        got_idx  = rsp_idx;
        got_data = rsp_data;
      end
    end
    rsp_ready = 1'b0;
    if (lat < 0) begin
      check("rsp_timeout", 0, 1);
    end else begin
      repeat (hold) step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_drop", rsp_valid, 0);
    end
  endtask

  initial begin
    int lat;
    logic h;
    logic [AW-1:0] ix;
    logic [D-2:0] dt;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_data = '0;
    clr = 1'b0; req_valid = 1'b0; req_key = '0; rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0; m_found = 1'b0;

    // Reset, then a search on the empty table misses after the full scan.
    step();
    step();
    check("ready_in_reset", req_ready, 0);
    rst_n = 1'b1;
    step();
    search(5, 0, 0, 0, 0, 0, 0, lat, h, ix, dt);
    check("t1_lat", lat, DEPTH + 1);
    check("t1_hit", h, 0);
    check("t1_idx", ix, 0);
    check("t1_data", dt, 0);

    // Single entry hit.
    write_entry(3, 5, 8'hA7);
    search(5, 0, 0, 0, 0, 0, 0, lat, h, ix, dt);
    check("t2_lat", lat, 5);
    check("t2_hit", h, 1);
    check("t2_idx", ix, 3);
    check("t2_data", dt, 7'h53);

    // Duplicate keys, response held back for 4 cycles.
    write_entry(1, 9, 8'h3C);
    write_entry(6, 9, 8'hF1);
    search(9, 4, 0, 0, 0, 0, 0, lat, h, ix, dt);
    check("t3_hit", h, 1);
    check("t3_idx", ix, 1);
    check("t3_lat", lat, 3);
    check("t3_data", dt, 7'h1E);

    // Mid-scan writes: ahead of the scan pointer vs already passed.
    clear_tbl();
    search(2, 0, 3, 0, 7, 2, 8'h81, lat, h, ix, dt);
    check("t4a_hit", h, 1);
    check("t4a_idx", ix, 7);
    check("t4a_lat", lat, 9);
    clear_tbl();
    search(2, 0, 3, 0, 0, 2, 8'h81, lat, h, ix, dt);
    check("t4b_hit", h, 0);
    check("t4b_lat", lat, DEPTH + 1);

    // clr wins over a same-cycle write.
    for (int i = 0; i < DEPTH; i++) write_entry(i, i + 1, 16 * i + 3);
    clr = 1'b1;
    write_entry(0, 1, 8'h55);
    clr = 1'b0;
    search(1, 0, 0, 0, 0, 0, 0, lat, h, ix, dt);
    check("t5_hit", h, 0);
    check("t5_lat", lat, DEPTH + 1);

    // Reset during scan aborts the search and empties the table.
    write_entry(7, 12, 8'hEE);
    req_valid = 1'b1;
    req_key   = 4'd12;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    step();
    check("t6_ready", req_ready, 1);
    repeat (10) step();
    check("t6_no_rsp", rsp_valid, 0);
    search(12, 0, 0, 0, 0, 0, 0, lat, h, ix, dt);
    check("t6_hit", h, 0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        write_entry($urandom_range(0, DEPTH - 1), $urandom_range(0, 5), $urandom_range(0, 255));
      end else if (r == 4) begin
        clear_tbl();
      end else if (r == 5) begin
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
      end else begin
        search($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, DEPTH + 1),
               ($urandom_range(0, 7) == 0), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 5), $urandom_range(0, 255), lat, h, ix, dt);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
